chardisp_vram_ctrl: RTL and testbench
=====================================

# chardisp_vram_ctrl

Write-port controller for `chardisp`: shares the single VRAM/config write port between a host requester and an internal fill sequencer. The fill sequencer clears the screen or writes a test pattern. Sits directly in front of `chardisp` WRITE_* inputs; all outputs are registered.

## Interface
- `VRAM_WORDS`, default 4000: number of 32-bit VRAM words covered by a fill.
- `CFG_ADDR`, default 16'h4000: display-config byte address. Passed through for host writes; never touched by fill.
- `CLK  in  1`: system clock.
- `RST  in  1`: reset; one clock, synchronous and active-high.
- `HOST_REQ  in  1`: host write request. Held until ack.
- `HOST_ADDR  in  16`: host byte address.
- `HOST_BE  in  4`: host byte enables.
- `HOST_DATA  in  32`: host write data.
- `HOST_ACK  out  1`: one-cycle pulse, coincident with the host's WRITE_EN cycle.
- `FILL_START  in  1`: start a fill (level sampled).
- `FILL_MODE  in  1`: 0 = constant `FILL_DATA`; 1 = index pattern.
- `FILL_DATA  in  32`: constant fill value.
- `FILL_BUSY  out  1`: fill in progress.
- `FILL_DONE  out  1`: one-cycle pulse at fill completion.
- `WRITE_ADDR  out  16`: to chardisp.
- `BYTE_EN  out  4`: to chardisp.
- `WRITE_EN  out  1`: to chardisp.
- `WRITE_DATA  out  32`: to chardisp.

## Operation
- Reset: all outputs 0; fill FSM to IDLE; fill index 0; round-robin pointer = host.
- Fill FSM has two states, IDLE and FILL.
  - IDLE → FILL when `FILL_START`=1 is sampled. The same edge latches `FILL_MODE` and `FILL_DATA`, clears the index, and sets `FILL_BUSY`.
  - In FILL, the fill source is eligible every cycle. Each grant writes address `idx<<2`, BYTE_EN 4'b1111, then increments idx.
  - Data in mode 0: latched `FILL_DATA`.
  - Data in mode 1: `((idx & 12'hfff) << 8) | (idx & 8'hff)`, zero-extended to 32 bits.
  - The grant with idx = `VRAM_WORDS-1` is the last write. FSM → IDLE, and `FILL_BUSY` falls at the same edge `FILL_DONE` rises.
  - `FILL_START` while BUSY is ignored. Parameters in use are not re-latched.
- Host eligibility: `HOST_REQ`=1 and `HOST_ACK`=0 in the current cycle. This blocks a double grant on the edge the host sees its ack.
- Arbitration:
  - One grant per cycle.
  - If only one source is eligible, it wins.
  - If both are eligible, the source not granted last wins, and the pointer updates on every grant.
  - No grant → WRITE_EN 0. WRITE_ADDR, BYTE_EN and WRITE_DATA hold their previous values.
- Host writes pass through unmodified, including CFG_ADDR and addresses beyond VRAM.

## Timing
- Host: REQ sampled at edge k and granted → WRITE_EN=1, HOST_ACK=1 and host fields on the outputs during cycle k+1. Host sustains at most one write every 2 cycles.
- Fill: START sampled at edge k → BUSY=1 from k+1, and the first fill WRITE_EN is in cycle k+2.
- Uncontended fill: `VRAM_WORDS` consecutive WRITE_EN cycles, followed by one cycle of `FILL_DONE`=1.
- Under contention with a continuously requesting host, fill and host grants alternate.
- `HOST_REQ` and `FILL_START` on the same edge in IDLE: host is granted at k+1, and fill starts per the rules above.
- RST mid-fill: the next cycle shows all outputs 0 and IDLE. No DONE pulse; an in-flight host request is not acked until re-arbitrated.

## Structure
- Package `chardisp_pkg`: `fill_state_t` (IDLE, FILL), `fill_mode_t` (CONST, INDEX), `grant_t` (NONE, HOST, FILL), default `CFG_ADDR`, and an index-pattern function.
- Index width: `$clog2(VRAM_WORDS)`.
- One sub-module: `chardisp_rr_arb2`. It is a 2-requester round-robin arbiter with a registered pointer that outputs a one-hot grant.

## Test plan
- Reset: hold RST 3 cycles with random inputs → every output 0, BUSY 0.
- Host single write: REQ with ADDR 16'h4000, BE 4'b1111, DATA 32'h1 → one cycle of WRITE_EN with those values and ACK in the same cycle. A held REQ produces no second write.
- Fill mode 1, `VRAM_WORDS`=8:
  - WRITE_ADDR 0,4,…,28 on 8 consecutive cycles.
  - Data `32'h00000000, 32'h00000101, …, 32'h00000707`.
  - DONE pulses once, immediately after.
- Contention: fill (mode 0, DATA 32'hDEADBEEF) running, host requests continuously → grants alternate. Every host write is acked exactly once, and fill still completes with all 8 addresses written once.
- START during BUSY with different DATA → ignored; all words carry the original DATA.
- RST asserted mid-fill at idx 3 → outputs 0 next cycle, no DONE. A new START refills from address 0.

Source files
------------

// File: rtl/chardisp_pkg.sv
// chardisp_pkg: shared types, defaults and the fill index pattern for the chardisp write-port controller
package chardisp_pkg;
    typedef enum logic {ST_IDLE, ST_FILL} fill_state_t;
    typedef enum logic {MODE_CONST, MODE_INDEX} fill_mode_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_HOST, GNT_FILL} grant_t;
    localparam logic [15:0] CFG_ADDR_DEFAULT = 16'h4000;
    function automatic logic [31:0] index_pattern(input logic [31:0] idx);
        return ((idx & 32'hfff) << 8) | (idx & 32'hff);
    endfunction
endpackage

// File: rtl/chardisp_rr_arb2.sv
// chardisp_rr_arb2: two-requester round-robin arbiter with registered priority pointer and one-hot grant
module chardisp_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic pri;
    always_comb begin
        gnt[0] = req[0] & (~req[1] | ~pri);
        gnt[1] = req[1] & (~req[0] | pri);
    end
    // pri=1 favours requester 1; it flips toward whoever was not just granted
    always_ff @(posedge clk)
        if (rst) pri <= 1'b0;
        else if (|gnt) pri <= gnt[0];
endmodule

// File: rtl/chardisp_vram_ctrl.sv
// chardisp_vram_ctrl: shares the chardisp write port between a host requester and a clear/pattern fill sequencer
module chardisp_vram_ctrl
    import chardisp_pkg::*;
#(
    parameter int          VRAM_WORDS = 4000,
    parameter logic [15:0] CFG_ADDR   = CFG_ADDR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HOST_REQ,
    input  logic [15:0] HOST_ADDR,
    input  logic [3:0]  HOST_BE,
    input  logic [31:0] HOST_DATA,
    output logic        HOST_ACK,
    input  logic        FILL_START,
    input  logic        FILL_MODE,
    input  logic [31:0] FILL_DATA,
    output logic        FILL_BUSY,
    output logic        FILL_DONE,
    output logic [15:0] WRITE_ADDR,
    output logic [3:0]  BYTE_EN,
    output logic        WRITE_EN,
    output logic [31:0] WRITE_DATA
);
    localparam int IW = VRAM_WORDS > 1 ? $clog2(VRAM_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(VRAM_WORDS - 1);

    fill_state_t   state;
    fill_mode_t    mode;
    logic [31:0]   fdata;
    logic [IW-1:0] idx;
    logic          fin;
    logic [1:0]    gnt;
    grant_t        g;
    logic          host_elig;
    logic [15:0]   fill_addr;
    logic [31:0]   fill_word;

    // a host that has just been acked is not eligible on the same edge
    assign host_elig = HOST_REQ & ~HOST_ACK;
    assign fill_addr = 16'({idx, 2'b00});
    assign fill_word = mode == MODE_INDEX ? index_pattern(32'(idx)) : fdata;
    assign g = gnt[0] ? GNT_HOST : gnt[1] ? GNT_FILL : GNT_NONE;

    chardisp_rr_arb2 u_arb (
        .clk(CLK),
        .rst(RST),
        .req({state == ST_FILL, host_elig}),
        .gnt(gnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            mode       <= MODE_CONST;
            fdata      <= '0;
            idx        <= '0;
            fin        <= 1'b0;
            HOST_ACK   <= 1'b0;
            FILL_BUSY  <= 1'b0;
            FILL_DONE  <= 1'b0;
            WRITE_ADDR <= '0;
            BYTE_EN    <= '0;
            WRITE_EN   <= 1'b0;
            WRITE_DATA <= '0;
        end else begin
            fin       <= g == GNT_FILL && idx == LAST;
            FILL_DONE <= fin;
            HOST_ACK  <= g == GNT_HOST;
            WRITE_EN  <= g != GNT_NONE;
            // BUSY spans the trailing cycle after the last grant so DONE and BUSY change together
            if (state == ST_IDLE && !FILL_BUSY && FILL_START) begin
                state     <= ST_FILL;
                mode      <= fill_mode_t'(FILL_MODE);
                fdata     <= FILL_DATA;
                idx       <= '0;
                FILL_BUSY <= 1'b1;
            end else if (fin) begin
                FILL_BUSY <= 1'b0;
            end
            if (g == GNT_FILL) begin
                idx <= idx + 1'b1;
                if (idx == LAST) state <= ST_IDLE;
            end
            if (g == GNT_HOST) begin
                WRITE_ADDR <= HOST_ADDR;
                BYTE_EN    <= HOST_BE;
                WRITE_DATA <= HOST_DATA;
            end else if (g == GNT_FILL) begin
                WRITE_ADDR <= fill_addr;
                BYTE_EN    <= fill_addr == CFG_ADDR ? 4'h0 : 4'hf;
                WRITE_DATA <= fill_word;
            end
        end
    end
endmodule

// File: tb/tb_chardisp_vram_ctrl.sv
// tb_chardisp_vram_ctrl: directed vector table plus hand-written multi-cycle sequences for chardisp_vram_ctrl
module tb_chardisp_vram_ctrl;
    logic        clk = 1'b0;
    logic        rst, req, start, mode;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data, fdata;
    logic        ack, busy, done, we;
    logic [15:0] waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, req;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        start, mode;
        logic [31:0] fdata;
        logic        e_we, e_ack;
        logic [15:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_data;
        logic        e_busy, e_done;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    chardisp_vram_ctrl #(.VRAM_WORDS(8)) dut (
        .CLK(clk), .RST(rst),
        .HOST_REQ(req), .HOST_ADDR(addr), .HOST_BE(be), .HOST_DATA(data), .HOST_ACK(ack),
        .FILL_START(start), .FILL_MODE(mode), .FILL_DATA(fdata),
        .FILL_BUSY(busy), .FILL_DONE(done),
        .WRITE_ADDR(waddr), .BYTE_EN(wbe), .WRITE_EN(we), .WRITE_DATA(wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_we, input logic e_ack, input logic [15:0] e_addr,
                           input logic [3:0] e_be, input logic [31:0] e_data, input logic e_busy, input logic e_done);
        chk({tag, ".we"}, 32'(we), 32'(e_we));
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
        chk({tag, ".addr"}, 32'(waddr), 32'(e_addr));
        chk({tag, ".be"}, 32'(wbe), 32'(e_be));
        chk({tag, ".data"}, wdata, e_data);
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    initial begin
        vecs[0]  = '{1, 1, 16'h1234, 4'h3, 32'h55, 1, 1, 32'h99, 0, 0, 16'h0, 4'h0, 32'h0, 0, 0};
        vecs[1]  = '{1, 0, 16'habcd, 4'hc, 32'h77, 1, 0, 32'h11, 0, 0, 16'h0, 4'h0, 32'h0, 0, 0};
        vecs[2]  = '{1, 1, 16'h0040, 4'hf, 32'h33, 0, 1, 32'h22, 0, 0, 16'h0, 4'h0, 32'h0, 0, 0};
        vecs[3]  = '{0, 1, 16'h4000, 4'hf, 32'h1, 0, 0, 32'h0, 1, 1, 16'h4000, 4'hf, 32'h1, 0, 0};
        vecs[4]  = '{0, 1, 16'h4000, 4'hf, 32'h1, 0, 0, 32'h0, 0, 0, 16'h4000, 4'hf, 32'h1, 0, 0};
        vecs[5]  = '{0, 0, 16'h0, 4'h0, 32'h0, 1, 1, 32'h0, 0, 0, 16'h4000, 4'hf, 32'h1, 1, 0};
        for (int i = 0; i < 8; i++)
            vecs[6+i] = '{0, 0, 16'h0, 4'h0, 32'h0, 0, 0, 32'h0, 1, 0, 16'(4*i), 4'hf, 32'(i * 32'h101), 1, 0};
        vecs[14] = '{0, 0, 16'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 0, 16'd28, 4'hf, 32'h707, 0, 1};
        vecs[15] = '{0, 0, 16'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 0, 16'd28, 4'hf, 32'h707, 0, 0};

        for (int v = 0; v < 16; v++) begin
            rst = vecs[v].rst; req = vecs[v].req; addr = vecs[v].addr; be = vecs[v].be;
            data = vecs[v].data; start = vecs[v].start; mode = vecs[v].mode; fdata = vecs[v].fdata;
            tick();
            chk_all($sformatf("vec%0d", v), vecs[v].e_we, vecs[v].e_ack, vecs[v].e_addr, vecs[v].e_be,
                    vecs[v].e_data, vecs[v].e_busy, vecs[v].e_done);
        end

        // contention: fill mode 0 against a continuously requesting host
        start = 1; mode = 0; fdata = 32'hdeadbeef;
        tick();
        chk_all("cont.start", 0, 0, 16'd28, 4'hf, 32'h707, 1, 0);
        start = 0; req = 1; addr = 16'h8000; be = 4'h3; data = 32'h1000;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c % 2 == 0) begin
                chk_all($sformatf("cont.h%0d", c / 2), 1, 1, 16'(16'h8000 + 4 * (c / 2)), 4'h3,
                        32'h1000 + 32'(c / 2), 1, 0);
                addr = 16'(16'h8000 + 4 * (c / 2 + 1));
                data = 32'h1000 + 32'(c / 2 + 1);
            end else begin
                chk_all($sformatf("cont.f%0d", c / 2), 1, 0, 16'(4 * (c / 2)), 4'hf, 32'hdeadbeef, 1, 0);
            end
        end
        tick();
        chk_all("cont.last_host", 1, 1, 16'h8020, 4'h3, 32'h1008, 0, 1);
        req = 0;
        tick();
        chk_all("cont.idle", 0, 0, 16'h8020, 4'h3, 32'h1008, 0, 0);

        // START during BUSY with different parameters is ignored
        start = 1; mode = 0; fdata = 32'haaaa5555;
        tick();
        chk_all("busy.start", 0, 0, 16'h8020, 4'h3, 32'h1008, 1, 0);
        mode = 1; fdata = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all($sformatf("busy.w%0d", i), 1, 0, 16'(4 * i), 4'hf, 32'haaaa5555, 1, 0);
            if (i == 2) start = 0;
        end
        tick();
        chk_all("busy.done", 0, 0, 16'd28, 4'hf, 32'haaaa5555, 0, 1);

        // reset mid-fill at idx 3, with a host request in flight
        start = 1; mode = 1; fdata = 32'h0;
        tick();
        chk("rst.busy", 32'(busy), 1);
        start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("rst.pre%0d", i), 1, 0, 16'(4 * i), 4'hf, 32'(i * 32'h101), 1, 0);
        end
        rst = 1; req = 1; addr = 16'h4000; be = 4'hf; data = 32'h5;
        tick();
        chk_all("rst.zero", 0, 0, 16'h0, 4'h0, 32'h0, 0, 0);
        rst = 0;
        tick();
        chk_all("rst.host_rearb", 1, 1, 16'h4000, 4'hf, 32'h5, 0, 0);
        req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("rst.nodone%0d", i), 0, 0, 16'h4000, 4'hf, 32'h5, 0, 0);
        end
        start = 1;
        tick();
        chk("refill.busy", 32'(busy), 1);
        start = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all($sformatf("refill.w%0d", i), 1, 0, 16'(4 * i), 4'hf, 32'(i * 32'h101), 1, 0);
        end
        tick();
        chk_all("refill.done", 0, 0, 16'd28, 4'hf, 32'h707, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
